// File: rtl/pipe_stall_flush_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: reset level,
// FSM state encoding, default stall bus width and a stage-index helper.
package pipe_stall_flush_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b0;
    localparam int   STALL_BUS  = 6;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Clamp a requested stall depth to the last existing stage
    function automatic int unsigned sat_stage(input int unsigned stg, input int unsigned top);
        return (stg > top) ? top : stg;
    endfunction

endpackage

// File: rtl/pipe_stall_flush_ctrl_stall_thermo_enc.sv
// Merges level stall requests into a thermometer stall vector: the deepest
// requested stage and every stage in front of it are held.
module stall_thermo_enc
    import pipe_stall_flush_ctrl_pkg::*;
#(
    parameter int                  NSTG    = STALL_BUS,
    parameter int                  NREQ    = 4,
    parameter logic [8*NREQ-1:0]   REQ_STG = {8'd3, 8'd2, 8'd2, 8'd1}
) (
    input  logic [NREQ-1:0] req_i,
    output logic [NSTG-1:0] stall_o
);

    localparam int unsigned TOP_STG = NSTG - 1;

    // OR together the thermometer masks of all asserted sources
    always_comb begin
        int unsigned lvl;
        lvl     = 0;
        stall_o = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (req_i[k]) begin
                lvl = sat_stage(32'(REQ_STG[8*k +: 8]), TOP_STG);
                for (int unsigned i = 0; i < NSTG; i++) begin
                    if (i <= lvl) stall_o[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_stall_flush_ctrl.sv
// Pipeline hazard controller: stall merging, multi-cycle flush sequencing
// with redirect PC, debug halt/resume, stall watchdog and perf counters.
module pipe_stall_flush_ctrl
    import pipe_stall_flush_ctrl_pkg::*;
#(
    parameter int                NSTG      = STALL_BUS,
    parameter int                NREQ      = 4,
    parameter logic [8*NREQ-1:0] REQ_STG   = {8'd3, 8'd2, 8'd2, 8'd1},
    parameter int                FLUSH_CYC = 1,
    parameter int                WDT_CYC   = 64,
    parameter int                CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_i,
    input  logic             flush_req_i,
    input  logic [31:0]      flush_pc_i,
    input  logic             halt_i,
    input  logic             resume_i,
    input  logic             cnt_clr_i,
    output logic [NSTG-1:0]  stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             halted_o,
    output logic             wdt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam bit          MULTI_CYC  = (FLUSH_CYC > 1);
    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYC - 1);
    localparam logic [31:0] WDT_LIM    = 32'(WDT_CYC);
    localparam bit          WDT_EN     = (WDT_CYC != 0);

    state_t           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic             pend_q, pend_d;
    logic [31:0]      pc_q;
    logic [31:0]      wdog_q;
    logic             wdt_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic [NSTG-1:0]  thermo;
    logic             stalling;
    logic             wdog_run;

    stall_thermo_enc #(
        .NSTG    (NSTG),
        .NREQ    (NREQ),
        .REQ_STG (REQ_STG)
    ) u_thermo (
        .req_i   (req_i),
        .stall_o (thermo)
    );

    // State register with flush countdown and pending-halt flag
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic; a flush request in any state restarts the flush,
    // and a halt seen around a flush is held until the flush drains
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pend_d  = pend_q;
        if (flush_req_i) begin
            pend_d = pend_q | halt_i | (state_q == ST_HALT);
            if (MULTI_CYC) begin
                state_d = ST_FLUSH;
                fcnt_d  = FLUSH_LOAD;
            end else begin
                state_d = pend_d ? ST_HALT : ST_RUN;
                pend_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (halt_i) state_d = ST_HALT;
                end
                ST_FLUSH: begin
                    pend_d = pend_q | halt_i;
                    if (fcnt_q == 4'd1) begin
                        state_d = pend_d ? ST_HALT : ST_RUN;
                        pend_d  = 1'b0;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - 4'd1;
                    end
                end
                ST_HALT: begin
                    if (resume_i) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Outputs: flush beats halt, halt beats requested stalls
    always_comb begin
        flush_o  = flush_req_i | (state_q == ST_FLUSH);
        new_pc_o = flush_req_i ? flush_pc_i : pc_q;
        halted_o = (state_q == ST_HALT);
        if (flush_o)                stall_o = '0;
        else if (state_q == ST_HALT) stall_o = '1;
        else                        stall_o = thermo;
    end

    assign stalling = |stall_o;
    assign wdog_run = stalling && (state_q != ST_HALT);

    // Redirect PC capture
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) pc_q <= '0;
        else if (flush_req_i)  pc_q <= flush_pc_i;
    end

    // Stall watchdog; counter saturates at the limit so the flag sets once
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            wdog_q <= '0;
            wdt_q  <= 1'b0;
        end else if (cnt_clr_i) begin
            wdog_q <= '0;
            wdt_q  <= 1'b0;
        end else if (wdog_run) begin
            if (wdog_q != WDT_LIM) wdog_q <= wdog_q + 32'd1;
            if (WDT_EN && (wdog_q + 32'd1 == WDT_LIM)) wdt_q <= 1'b1;
        end else begin
            wdog_q <= '0;
        end
    end

    // Performance counters, wrapping, clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stalling)    stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_req_i) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign wdt_o       = wdt_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Randomized and directed bench for pipe_stall_flush_ctrl against a
// behavioural reference model.
module tb_pipe_stall_flush_ctrl;

    localparam int FC   = 3;
    localparam int WDT  = 64;
    localparam int CW   = 4;
    localparam int NSTG = 6;

    logic        clk;
    logic        rst;
    logic [3:0]  req_i;
    logic        flush_req_i;
    logic [31:0] flush_pc_i;
    logic        halt_i;
    logic        resume_i;
    logic        cnt_clr_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        halted_o;
    logic        wdt_o;
    logic [3:0]  stall_cnt_o;
    logic [3:0]  flush_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Per-source stall depth; source 1 deliberately exceeds the stage count
    int req_tab [4] = '{1, 200, 2, 3};

    pipe_stall_flush_ctrl #(
        .NSTG      (NSTG),
        .NREQ      (4),
        .REQ_STG   ({8'd3, 8'd2, 8'd200, 8'd1}),
        .FLUSH_CYC (FC),
        .WDT_CYC   (WDT),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .flush_req_i (flush_req_i),
        .flush_pc_i  (flush_pc_i),
        .halt_i      (halt_i),
        .resume_i    (resume_i),
        .cnt_clr_i   (cnt_clr_i),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .new_pc_o    (new_pc_o),
        .halted_o    (halted_o),
        .wdt_o       (wdt_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int          m_left;   // flush_o cycles still owed after the current one
    bit          m_halted;
    bit          m_pend;
    logic [31:0] m_pc;
    int          m_run;    // consecutive stalled, non-halted cycles
    bit          m_wdt;
    int          m_scnt;
    int          m_fcnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_thermo(input logic [3:0] req);
        int m = -1;
        int s;
        for (int k = 0; k < 4; k++) begin
            if (req[k]) begin
                s = (req_tab[k] > NSTG - 1) ? NSTG - 1 : req_tab[k];
                if (s > m) m = s;
            end
        end
        return (m < 0) ? 6'd0 : 6'((1 << (m + 1)) - 1);
    endfunction

    function automatic logic [5:0] exp_stall();
        if (flush_req_i || m_left > 0) return 6'd0;
        if (m_halted) return 6'h3f;
        return exp_thermo(req_i);
    endfunction

    task automatic model_reset();
        m_left = 0; m_halted = 0; m_pend = 0; m_pc = 0;
        m_run = 0; m_wdt = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_step();
        bit st;
        st = (exp_stall() != 0);
        if (cnt_clr_i) begin
            m_scnt = 0; m_fcnt = 0; m_run = 0; m_wdt = 0;
        end else begin
            if (st) m_scnt = (m_scnt + 1) % (1 << CW);
            if (flush_req_i) m_fcnt = (m_fcnt + 1) % (1 << CW);
            if (st && !m_halted && m_left == 0) begin
                m_run++;
                if (m_run == WDT) m_wdt = 1;
            end else begin
                m_run = 0;
            end
        end
        if (flush_req_i) begin
            m_pc     = flush_pc_i;
            m_pend   = m_pend | halt_i | m_halted;
            m_halted = 0;
            m_left   = FC - 1;
            if (m_left == 0 && m_pend) begin m_halted = 1; m_pend = 0; end
        end else if (m_left > 0) begin
            m_pend = m_pend | halt_i;
            m_left--;
            if (m_left == 0 && m_pend) begin m_halted = 1; m_pend = 0; end
        end else if (m_halted) begin
            if (resume_i) m_halted = 0;
        end else if (halt_i) begin
            m_halted = 1;
        end
    endtask

    task automatic check_all();
        check_eq("stall_o",     32'(stall_o),     32'(exp_stall()));
        check_eq("flush_o",     32'(flush_o),     32'(flush_req_i | (m_left > 0)));
        check_eq("new_pc_o",    new_pc_o,         flush_req_i ? flush_pc_i : m_pc);
        check_eq("halted_o",    32'(halted_o),    32'(m_halted));
        check_eq("wdt_o",       32'(wdt_o),       32'(m_wdt));
        check_eq("stall_cnt_o", 32'(stall_cnt_o), 32'(m_scnt));
        check_eq("flush_cnt_o", 32'(flush_cnt_o), 32'(m_fcnt));
    endtask

    // One clock: check mid-cycle, advance model on the edge, leave inputs
    // free to change 1 time unit after the edge
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        #1;
    endtask

    task automatic idle_inputs();
        req_i = '0; flush_req_i = 0; flush_pc_i = '0;
        halt_i = 0; resume_i = 0; cnt_clr_i = 0;
    endtask

    task automatic async_reset();
        #1 rst = 1'b0;
        model_reset();
        idle_inputs();
        #1;
        check_eq("rst_stall",  32'(stall_o),  32'd0);
        check_eq("rst_flush",  32'(flush_o),  32'd0);
        check_eq("rst_pc",     new_pc_o,      32'd0);
        check_eq("rst_halted", 32'(halted_o), 32'd0);
        check_eq("rst_cnt",    32'(stall_cnt_o) | 32'(flush_cnt_o) | 32'(wdt_o), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check_eq("post_rst_stall", 32'(stall_o), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        tick(); tick();
        rst = 1'b1;
        tick();

        // Thermometer merge, including a saturated source
        req_i = 4'b0001; #1 check_eq("thermo_0001", 32'(stall_o), 32'h03);
        req_i = 4'b1001; #1 check_eq("thermo_1001", 32'(stall_o), 32'h0f);
        req_i = 4'b0010; #1 check_eq("thermo_sat",  32'(stall_o), 32'h3f);
        req_i = 4'b0000; #1 check_eq("thermo_none", 32'(stall_o), 32'h00);
        tick();

        // Three-cycle flush with a full stall request underneath
        cnt_clr_i = 1; tick(); cnt_clr_i = 0;
        req_i = 4'b1111; flush_req_i = 1; flush_pc_i = 32'h8000_0180;
        #1 check_eq("fl_c1_flush", 32'(flush_o), 32'd1);
        check_eq("fl_c1_stall", 32'(stall_o), 32'd0);
        check_eq("fl_c1_pc", new_pc_o, 32'h8000_0180);
        tick();
        flush_req_i = 0; flush_pc_i = 32'h1234_5678;
        for (int c = 2; c <= 3; c++) begin
            #1 check_eq("fl_hold_flush", 32'(flush_o), 32'd1);
            check_eq("fl_hold_pc", new_pc_o, 32'h8000_0180);
            check_eq("fl_hold_stall", 32'(stall_o), 32'd0);
            tick();
        end
        check_eq("fl_end_flush", 32'(flush_o), 32'd0);
        check_eq("fl_end_stall", 32'(stall_o), 32'h3f);
        check_eq("fl_cnt", 32'(flush_cnt_o), 32'd1);

        // Halt arriving during a flush is taken when the flush ends
        req_i = 4'b0001; flush_req_i = 1; flush_pc_i = 32'h0000_0400; tick();
        flush_req_i = 0; halt_i = 1; tick();
        halt_i = 0; tick();
        check_eq("halt_after_flush", 32'(halted_o), 32'd1);
        check_eq("halt_stall", 32'(stall_o), 32'h3f);
        tick(); tick();
        resume_i = 1; tick(); resume_i = 0;
        check_eq("resume_run", 32'(halted_o), 32'd0);
        check_eq("resume_stall", 32'(stall_o), 32'h03);

        // Async reset mid-FLUSH and mid-HALT
        flush_req_i = 1; tick(); flush_req_i = 0;
        async_reset();
        halt_i = 1; tick(); halt_i = 0; tick();
        async_reset();

        // Watchdog: 64 consecutive stalled cycles
        cnt_clr_i = 1; tick(); cnt_clr_i = 0;
        req_i = 4'b0100;
        for (int c = 0; c < 63; c++) tick();
        check_eq("wdt_before", 32'(wdt_o), 32'd0);
        tick();
        check_eq("wdt_at_64", 32'(wdt_o), 32'd1);
        req_i = 4'b0000;
        tick(); tick();
        check_eq("wdt_sticky", 32'(wdt_o), 32'd1);
        cnt_clr_i = 1; tick(); cnt_clr_i = 0;
        check_eq("wdt_clr", 32'(wdt_o), 32'd0);
        check_eq("scnt_clr", 32'(stall_cnt_o), 32'd0);

        // Four-bit counter wrap, then clear beating a concurrent stall
        req_i = 4'b0001;
        for (int c = 0; c < 17; c++) tick();
        check_eq("scnt_wrap", 32'(stall_cnt_o), 32'd1);
        cnt_clr_i = 1; tick(); cnt_clr_i = 0;
        check_eq("scnt_clr_win", 32'(stall_cnt_o), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_i       = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            flush_req_i = ($urandom_range(0, 9) == 0);
            flush_pc_i  = $urandom;
            halt_i      = ($urandom_range(0, 11) == 0);
            resume_i    = ($urandom_range(0, 5) == 0);
            cnt_clr_i   = ($urandom_range(0, 59) == 0);
            if (c % 1000 == 999) async_reset();
            else tick();
        end

        // Long stall runs so the watchdog fires under random request mixes
        idle_inputs();
        for (int c = 0; c < 300; c++) begin
            req_i     = 4'($urandom_range(1, 15));
            cnt_clr_i = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
